mem_access_ctrl: RTL

//  Memory-stage access controller between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns the M-stage load/store into a req/ack
// bus transaction, stalls the pipeline until it completes, and flags faults.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemFaultM
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t          state;
    logic [TO_W-1:0] count;
    logic            acc;
    logic            bad;

    assign acc    = MemReadM | MemWriteM;
    assign bad    = (MemReadM & MemWriteM) | (acc & (ALUOutM[1:0] != 2'b00));
    assign StallM = ((state == IDLE) & acc & ~bad) | (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadDataM <= '0;
            MemFaultM <= 1'b0;
        end else begin
            MemFaultM <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (bad) begin
                            MemFaultM <= 1'b1;
                            ReadDataM <= '0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWriteM;
                            mem_addr  <= {ALUOutM[31:2], 2'b00};
                            mem_wdata <= WriteDataM;
                            count     <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    count <= count + 1'b1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadDataM <= mem_rdata;
                        end
                        state <= DONE;
                    end else if (count == TO_W'(TIMEOUT - 1)) begin
                        mem_req   <= 1'b0;
                        ReadDataM <= '0;
                        MemFaultM <= 1'b1;
                        state     <= DONE;
                    end
                end
                // Single release cycle; the held instruction advances, so no re-issue here.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
